// File: rtl/cp0_regfile_if.sv
// Bus between the exception detector / execute stage and the CP0 register file.
// The master side drives commit strobes and mtc0/mfc0 traffic; the slave is cp0_regfile.
interface cp0_regfile_if;
    logic        except;
    logic [31:0] cause_in;
    logic [31:0] state_in;
    logic [31:0] badpc_in;
    logic [31:0] badaddr_in;
    logic [5:0]  hw_int;
    logic        mtc0_we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        eret;
    logic        int_req;
    logic        exl;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output except, cause_in, state_in, badpc_in, badaddr_in, hw_int,
        output mtc0_we, wr_addr, wr_data, rd_addr, eret,
        input  rd_data, int_req, exl, redirect, redirect_pc
    );

    modport slave (
        input  except, cause_in, state_in, badpc_in, badaddr_in, hw_int,
        input  mtc0_we, wr_addr, wr_data, rd_addr, eret,
        output rd_data, int_req, exl, redirect, redirect_pc
    );
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file: EPC/Cause/Status/BadVAddr, Count/Compare timer, interrupt request, fetch redirect.
// Optional timer guarded by macro CP0_TIMER_EN (undefined: Count/Compare read 0, TI tied low).
module cp0_regfile #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic         clk,
    input  logic         rst_n,
    cp0_regfile_if.slave bus
);
    localparam logic [4:0] A_BADVADDR = 5'd8;
    localparam logic [4:0] A_COUNT    = 5'd9;
    localparam logic [4:0] A_COMPARE  = 5'd11;
    localparam logic [4:0] A_STATUS   = 5'd12;
    localparam logic [4:0] A_CAUSE    = 5'd13;
    localparam logic [4:0] A_EPC      = 5'd14;

    logic [31:0] r_status;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic        r_bd;
    logic [4:0]  r_exc;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;

    logic        w_ti;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_wr_en;
    logic        w_bad_code;
    logic [31:0] w_cause;
    logic [31:0] w_rd_data;
    logic        w_unused_cause;

    // mtc0 only commits when no exception or eret claims the cycle
    assign w_wr_en    = bus.mtc0_we & ~bus.except & ~bus.eret;
    assign w_bad_code = (bus.cause_in[6:2] == 5'd4) || (bus.cause_in[6:2] == 5'd5);
    assign w_unused_cause = ^{bus.cause_in[30:7], bus.cause_in[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_status      <= 32'h0040_0000;
            r_epc         <= '0;
            r_badvaddr    <= '0;
            r_bd          <= 1'b0;
            r_exc         <= '0;
            r_ip_hw       <= '0;
            r_ip_sw       <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_ip_hw    <= {bus.hw_int[5] | w_ti, bus.hw_int[4:0]};
            r_redirect <= bus.except | bus.eret;
            if (bus.except) begin
                r_status <= bus.state_in;
                r_exc    <= bus.cause_in[6:2];
                // Nested exceptions keep the original EPC and BD
                if (!r_status[1]) begin
                    r_epc <= bus.badpc_in;
                    r_bd  <= bus.cause_in[31];
                end
                if (w_bad_code)
                    r_badvaddr <= bus.badaddr_in;
                r_redirect_pc <= EXC_VECTOR;
            end else if (bus.eret) begin
                r_status[1]   <= 1'b0;
                r_redirect_pc <= r_epc;
            end else if (w_wr_en) begin
                case (bus.wr_addr)
                    A_STATUS: r_status <= {r_status[31:16], bus.wr_data[15:8],
                                           r_status[7:2], bus.wr_data[1:0]};
                    A_CAUSE:  r_ip_sw  <= bus.wr_data[9:8];
                    A_EPC:    r_epc    <= bus.wr_data;
                    default:  ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_tog;
    logic        r_ti;

    // Count advances on the edges where the toggle is high, i.e. every second cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_compare <= '0;
            r_tog     <= 1'b0;
            r_ti      <= 1'b0;
        end else begin
            r_tog <= ~r_tog;
            if (w_wr_en && bus.wr_addr == A_COUNT)
                r_count <= bus.wr_data;
            else if (r_tog)
                r_count <= r_count + 32'd1;
            if (w_wr_en && bus.wr_addr == A_COMPARE) begin
                r_compare <= bus.wr_data;
                r_ti      <= 1'b0;
            end else if (r_tog && (r_count == r_compare)) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign w_ti      = r_ti;
    assign w_count   = r_count;
    assign w_compare = r_compare;
`else
    assign w_ti      = 1'b0;
    assign w_count   = '0;
    assign w_compare = '0;
`endif

    assign w_cause = {r_bd, w_ti, 14'b0, r_ip_hw, r_ip_sw, 1'b0, r_exc, 2'b00};

    always_comb begin
        w_rd_data = '0;
        case (bus.rd_addr)
            A_BADVADDR: w_rd_data = r_badvaddr;
            A_COUNT:    w_rd_data = w_count;
            A_COMPARE:  w_rd_data = w_compare;
            A_STATUS:   w_rd_data = r_status;
            A_CAUSE:    w_rd_data = w_cause;
            A_EPC:      w_rd_data = r_epc;
            default:    w_rd_data = '0;
        endcase
    end

    assign bus.rd_data     = w_rd_data;
    assign bus.exl         = r_status[1];
    assign bus.int_req     = r_status[0] & ~r_status[1] &
                             (|({r_ip_hw, r_ip_sw} & r_status[15:8]));
    assign bus.redirect    = r_redirect;
    assign bus.redirect_pc = r_redirect_pc;
endmodule

// File: tb/tb_cp0_regfile.sv
// Directed vector bench for cp0_regfile: table of single-cycle operations plus
// hand-written sequences for reset, no-bypass reads, the timer and mid-operation reset.
module tb_cp0_regfile;
    logic clk;
    logic rst_n;
    cp0_regfile_if bus();

    cp0_regfile #(.EXC_VECTOR(32'hBFC0_0380)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ex;
        logic        er;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] cause;
        logic [31:0] state;
        logic [31:0] bpc;
        logic [31:0] badr;
        logic [5:0]  hw;
        logic [4:0]  ra;
        logic [31:0] exp_rd;
        logic        exp_redir;
        logic [31:0] exp_pc;
        logic        exp_int;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input logic ex, input logic er, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [31:0] cause, input logic [31:0] state,
                       input logic [31:0] bpc, input logic [31:0] badr, input logic [5:0] hw,
                       input logic [4:0] ra, input logic [31:0] exp_rd, input logic exp_redir,
                       input logic [31:0] exp_pc, input logic exp_int);
        vq.push_back('{ex, er, we, wa, wd, cause, state, bpc, badr, hw, ra,
                       exp_rd, exp_redir, exp_pc, exp_int});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.mtc0_we = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.mtc0_we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        bus.rd_addr = a;
        #1;
        check(name, bus.rd_data, exp);
    endtask

    initial begin
        bus.except = 0; bus.eret = 0; bus.mtc0_we = 0;
        bus.cause_in = '0; bus.state_in = '0; bus.badpc_in = '0; bus.badaddr_in = '0;
        bus.hw_int = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        rst_n = 1'b0;

        // Reset: held low for two edges, checked while still in reset
        tick(); tick();
        rd_chk("rst_status", 5'd12, 32'h0040_0000);
        rd_chk("rst_cause",  5'd13, 32'h0);
        rd_chk("rst_epc",    5'd14, 32'h0);
        rd_chk("rst_bad",    5'd8,  32'h0);
        rd_chk("rst_count",  5'd9,  32'h0);
        rd_chk("rst_cmp",    5'd11, 32'h0);
        check("rst_redirect", {31'b0, bus.redirect}, 32'h0);
        check("rst_int", {31'b0, bus.int_req}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef CP0_TIMER_EN
        // Move Compare far away so TI stays clear during the table
        wr(5'd11, 32'hFFFF_0000);
`else
        wr(5'd9, 32'h0000_0055);
        rd_chk("notimer_count", 5'd9, 32'h0);
        wr(5'd11, 32'h0000_0055);
        rd_chk("notimer_cmp", 5'd11, 32'h0);
`endif

        //   ex er we wa     wd            cause         state         bpc           badr          hw     ra     exp_rd        rd pc            int
        add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd12, 32'h0040_0000, 0, 32'h0,        0);
        add(0, 0, 1, 5'd13, 32'hFFFF_FFFF,32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd13, 32'h0000_0300, 0, 32'h0,        0);
        add(0, 0, 1, 5'd13, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd13, 32'h0,         0, 32'h0,        0);
        add(0, 0, 1, 5'd8,  32'hFFFF_FFFF,32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd8,  32'h0,         0, 32'h0,        0);
        add(0, 0, 1, 5'd12, 32'hFFFF_FFFF,32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd12, 32'h0040_FF03, 0, 32'h0,        0);
        add(0, 0, 1, 5'd12, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd12, 32'h0040_0000, 0, 32'h0,        0);
        add(0, 0, 1, 5'd14, 32'h1111_2222,32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd14, 32'h1111_2222, 0, 32'h0,        0);
        add(0, 0, 1, 5'd3,  32'hFFFF_FFFF,32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd3,  32'h0,         0, 32'h0,        0);
        add(1, 0, 0, 5'd0,  32'h0,        32'h8000_0014,32'h0040_0002,32'h0040_0100,32'h1234_5679,6'h00, 5'd13, 32'h8000_0014, 1, 32'hBFC0_0380,0);
        add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd14, 32'h0040_0100, 0, 32'h0,        0);
        add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd8,  32'h1234_5679, 0, 32'h0,        0);
        add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd12, 32'h0040_0002, 0, 32'h0,        0);
        add(1, 0, 0, 5'd0,  32'h0,        32'h0000_0030,32'h0040_0002,32'h0040_0200,32'hAAAA_0000,6'h00, 5'd13, 32'h8000_0030, 1, 32'hBFC0_0380,0);
        add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd14, 32'h0040_0100, 0, 32'h0,        0);
        add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd8,  32'h1234_5679, 0, 32'h0,        0);
        add(0, 1, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd12, 32'h0040_0000, 1, 32'h0040_0100,0);
        add(1, 0, 1, 5'd14, 32'hDEAD_BEEF,32'h0000_0010,32'h0040_0002,32'h0040_0300,32'h0000_0BAD,6'h00, 5'd14, 32'h0040_0300, 1, 32'hBFC0_0380,0);
        add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd8,  32'h0000_0BAD, 0, 32'h0,        0);
        add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd13, 32'h0000_0010, 0, 32'h0,        0);
        add(0, 1, 1, 5'd14, 32'h5555_5555,32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd14, 32'h0040_0300, 1, 32'h0040_0300,0);
        add(0, 1, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd12, 32'h0040_0000, 1, 32'h0040_0300,0);
        add(0, 0, 1, 5'd12, 32'h0000_0401,32'h0,        32'h0,        32'h0,        32'h0,        6'h01, 5'd12, 32'h0040_0401, 0, 32'h0,        1);
        add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd13, 32'h0000_0010, 0, 32'h0,        0);
        add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h20, 5'd13, 32'h0000_8010, 0, 32'h0,        0);
        add(0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        6'h00, 5'd13, 32'h0000_0010, 0, 32'h0,        0);

        foreach (vq[i]) begin
            @(negedge clk);
            bus.except = vq[i].ex;       bus.eret = vq[i].er;        bus.mtc0_we = vq[i].we;
            bus.wr_addr = vq[i].wa;      bus.wr_data = vq[i].wd;     bus.cause_in = vq[i].cause;
            bus.state_in = vq[i].state;  bus.badpc_in = vq[i].bpc;   bus.badaddr_in = vq[i].badr;
            bus.hw_int = vq[i].hw;
            tick();
            bus.except = 0; bus.eret = 0; bus.mtc0_we = 0;
            rd_chk($sformatf("vec%0d_rd", i), vq[i].ra, vq[i].exp_rd);
            check($sformatf("vec%0d_redirect", i), {31'b0, bus.redirect}, {31'b0, vq[i].exp_redir});
            if (vq[i].exp_redir)
                check($sformatf("vec%0d_pc", i), bus.redirect_pc, vq[i].exp_pc);
            check($sformatf("vec%0d_int", i), {31'b0, bus.int_req}, {31'b0, vq[i].exp_int});
        end

        // Same-cycle read of a register being written returns the old value
        @(negedge clk);
        bus.mtc0_we = 1'b1; bus.wr_addr = 5'd14; bus.wr_data = 32'h0BAD_F00D;
        rd_chk("nobypass_old", 5'd14, 32'h0040_0300);
        tick();
        bus.mtc0_we = 1'b0;
        rd_chk("nobypass_new", 5'd14, 32'h0BAD_F00D);

`ifdef CP0_TIMER_EN
        wr(5'd11, 32'd10);
        wr(5'd9, 32'd0);
        wr(5'd12, 32'h0000_8001);
        for (int i = 0; i < 60 && !bus.int_req; i++) tick();
        check("timer_int", {31'b0, bus.int_req}, 32'h1);
        rd_chk("timer_ti", 5'd13, 32'h4000_8010);
        tick(); tick(); tick();
        check("timer_ti_hold", {31'b0, bus.int_req}, 32'h1);
        wr(5'd11, 32'd100);
        tick();
        check("timer_int_clr", {31'b0, bus.int_req}, 32'h0);
        rd_chk("timer_ti_clr", 5'd13, 32'h0000_0010);
        wr(5'd9, 32'hFFFF_FFFF);
        tick(); tick();
        rd_chk("timer_wrap", 5'd9, 32'h0);
`endif

        // Reset while a redirect pulse is in flight
        @(negedge clk);
        bus.except = 1'b1; bus.cause_in = 32'h0000_0014; bus.state_in = 32'h0040_0002;
        bus.badpc_in = 32'h0040_0500; bus.badaddr_in = 32'h0000_1000;
        tick();
        check("midrst_pre", {31'b0, bus.redirect}, 32'h1);
        @(negedge clk);
        bus.except = 1'b0;
        rst_n = 1'b0;
        tick();
        check("midrst_redirect", {31'b0, bus.redirect}, 32'h0);
        check("midrst_pc", bus.redirect_pc, 32'h0);
        rd_chk("midrst_status", 5'd12, 32'h0040_0000);
        rd_chk("midrst_epc", 5'd14, 32'h0);
        rd_chk("midrst_bad", 5'd8, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
